// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI register target.
package spi_target_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StData,
    StDrain
  } state_e;

  localparam int unsigned CMD_RW_BIT = 7;
  localparam int unsigned ADDR_W     = 4;
  localparam int unsigned BYTE_W     = 8;
  // Address field carried in the command byte.
  localparam int unsigned CMD_ADDR_W = 7;

  // Next burst address, wrapping from the last register back to zero.
  function automatic logic [CMD_ADDR_W-1:0] addr_wrap_inc(input logic [CMD_ADDR_W-1:0] addr,
                                                          input int unsigned num_regs);
    if (addr == CMD_ADDR_W'(num_regs - 1)) begin
      return '0;
    end
    return addr + CMD_ADDR_W'(1);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input plus a one-flop
// rise/fall pulse detector on the synchronized level.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchronizer chain followed by the edge-detector history flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~prev_q;
  assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/spi_reg_target.sv
// SPI mode-0 target decoding 2-byte {rw, addr[6:0]} / data frames into a
// small register file. Optional burst addressing: define SPI_AUTOINC_EN.
module spi_reg_target
  import spi_target_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic                       sclk_i,
  input  logic                       cs_n_i,
  input  logic                       mosi_i,
  output logic                       miso_o,
  output logic                       miso_oe,
  output logic [NUM_REGS*BYTE_W-1:0] regs_o,
  output logic                       wr_strobe_o,
  output logic [ADDR_W-1:0]          wr_addr_o
);

  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic cs_n_s, cs_fall, cs_rise_unused;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s, cs_active;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .din_i  (sclk_i),
    .level_o(sclk_lvl_unused),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .din_i  (cs_n_i),
    .level_o(cs_n_s),
    .rise_o (cs_rise_unused),
    .fall_o (cs_fall)
  );

  // MOSI has the same synchronizer depth as SCLK so it is sampled aligned to the rise pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_sync_q <= '0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
    end
  end

  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_active = ~cs_n_s & ena;
  assign miso_oe   = cs_active;

  state_e                          state_q, state_d;
  logic [2:0]                      cnt_q, cnt_d;
  logic [BYTE_W-2:0]               shift_in_q, shift_in_d;
  logic [BYTE_W-1:0]               shift_out_q, shift_out_d;
  logic                            rw_q, rw_d;
  logic [CMD_ADDR_W-1:0]           addr_q, addr_d;
  logic                            miso_q, miso_d;
  logic [NUM_REGS-1:0][BYTE_W-1:0] regs_q, regs_d;
  logic                            wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0]               wr_addr_q, wr_addr_d;
  logic [BYTE_W-1:0]               byte_in;
  logic                            addr_in_range;

  function automatic logic [BYTE_W-1:0] rd_reg(input logic [NUM_REGS-1:0][BYTE_W-1:0] rf,
                                               input logic [CMD_ADDR_W-1:0] a);
    logic [BYTE_W-1:0] val;
    val = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (a == CMD_ADDR_W'(k)) val = rf[k];
    end
    return val;
  endfunction

  assign byte_in       = {shift_in_q, mosi_s};
  assign addr_in_range = addr_q < CMD_ADDR_W'(NUM_REGS);

  // Next-state, shift and register-file update; a CS release overrides any SCLK edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    miso_d      = miso_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    if (!cs_active) begin
      state_d = StIdle;
      cnt_d   = '0;
      miso_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cs_fall) begin
            state_d = StCmd;
            cnt_d   = '0;
            miso_d  = 1'b0;
          end
        end
        StCmd: begin
          if (sclk_rise) begin
            shift_in_d = byte_in[BYTE_W-2:0];
            cnt_d      = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              rw_d        = byte_in[CMD_RW_BIT];
              addr_d      = byte_in[CMD_ADDR_W-1:0];
              shift_out_d = byte_in[CMD_RW_BIT] ? '0 : rd_reg(regs_q, byte_in[CMD_ADDR_W-1:0]);
              state_d     = StData;
            end
          end
        end
        StData: begin
          if (sclk_rise) begin
            shift_in_d = byte_in[BYTE_W-2:0];
            cnt_d      = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (rw_q && addr_in_range) begin
                for (int unsigned k = 0; k < NUM_REGS; k++) begin
                  if (addr_q == CMD_ADDR_W'(k)) regs_d[k] = byte_in;
                end
                wr_strobe_d = 1'b1;
                wr_addr_d   = addr_q[ADDR_W-1:0];
              end
`ifdef SPI_AUTOINC_EN
              addr_d      = addr_wrap_inc(addr_q, NUM_REGS);
              shift_out_d = rw_q ? '0 : rd_reg(regs_q, addr_wrap_inc(addr_q, NUM_REGS));
`else
              state_d     = StDrain;
              miso_d      = 1'b0;
`endif
            end
          end else if (sclk_fall) begin
            miso_d      = shift_out_q[BYTE_W-1];
            shift_out_d = {shift_out_q[BYTE_W-2:0], 1'b0};
          end
        end
        StDrain: begin
          miso_d = 1'b0;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shift_in_q  <= '0;
      shift_out_q <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      miso_q      <= 1'b0;
      regs_q      <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      miso_q      <= miso_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
    end
  end

  assign miso_o      = miso_q;
  assign regs_o      = regs_q;
  assign wr_strobe_o = wr_strobe_q;
  assign wr_addr_o   = wr_addr_q;

endmodule

// File: tb/tb_spi_reg_target.sv
// Directed bench for spi_reg_target: host-side SPI mode-0 frames with
// hand-computed register, strobe and MISO expectations.
module tb_spi_reg_target;

  localparam int HALF = 6;  // SCLK half period in clk cycles

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        sclk;
  logic        cs_n;
  logic        mosi;
  logic        miso_o;
  logic        miso_oe;
  logic [31:0] regs_o;
  logic        wr_strobe_o;
  logic [3:0]  wr_addr_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          strobe_cnt = 0;
  logic [3:0]  strobe_addr = '0;

  spi_reg_target #(.NUM_REGS(4), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .sclk_i     (sclk),
    .cs_n_i     (cs_n),
    .mosi_i     (mosi),
    .miso_o     (miso_o),
    .miso_oe    (miso_oe),
    .regs_o     (regs_o),
    .wr_strobe_o(wr_strobe_o),
    .wr_addr_o  (wr_addr_o)
  );

  always #5 clk = ~clk;

  // Strobe monitor: counts high cycles and records the address seen with each.
  always @(negedge clk) begin
    if (wr_strobe_o) begin
      strobe_cnt  <= strobe_cnt + 1;
      strobe_addr <= wr_addr_o;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Host frame: MSB-first from tx[23], MISO captured on each SCLK rise.
  task automatic spi_frame(input logic [23:0] tx, input int nbits,
                           output logic [23:0] rx, output logic oe_hi);
    rx    = '0;
    oe_hi = 1'b1;
    cs_n  = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[23-i];
      wait_clk(HALF);
      sclk  = 1'b1;
      rx    = {rx[22:0], miso_o};
      oe_hi = oe_hi & miso_oe;
      wait_clk(HALF);
      sclk = 1'b0;
    end
    wait_clk(HALF);
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_clk(2 * HALF);
  endtask

  logic [23:0] rx;
  logic        oe_hi;
  int          s0;
  logic [31:0] exp_regs;

  initial begin
    rst_n = 1'b0;
    ena   = 1'b1;
    sclk  = 1'b0;
    cs_n  = 1'b1;
    mosi  = 1'b0;
    wait_clk(3);
    check_eq("rst_regs", regs_o, 32'h0);
    check_eq("rst_miso", {31'h0, miso_o}, 32'h0);
    check_eq("rst_oe", {31'h0, miso_oe}, 32'h0);
    check_eq("rst_strobe", {31'h0, wr_strobe_o}, 32'h0);
    check_eq("rst_waddr", {28'h0, wr_addr_o}, 32'h0);
    rst_n = 1'b1;
    wait_clk(4);

    // Write reg1 = 0xA5.
    s0 = strobe_cnt;
    spi_frame(24'h81A500, 16, rx, oe_hi);
    check_eq("wr1_regs", regs_o, 32'h0000A500);
    check_eq("wr1_strobes", strobe_cnt - s0, 1);
    check_eq("wr1_saddr", {28'h0, strobe_addr}, 32'h1);
    check_eq("wr1_waddr_hold", {28'h0, wr_addr_o}, 32'h1);

    // Read reg1 back.
    s0 = strobe_cnt;
    spi_frame(24'h010000, 16, rx, oe_hi);
    check_eq("rd1_cmd_miso", {24'h0, rx[15:8]}, 32'h0);
    check_eq("rd1_data", {24'h0, rx[7:0]}, 32'hA5);
    check_eq("rd1_oe_during", {31'h0, oe_hi}, 32'h1);
    check_eq("rd1_oe_after", {31'h0, miso_oe}, 32'h0);
    check_eq("rd1_strobes", strobe_cnt - s0, 0);

    // Out-of-range read and write.
    s0 = strobe_cnt;
    spi_frame(24'h7F0000, 16, rx, oe_hi);
    check_eq("rd_oor_data", {24'h0, rx[7:0]}, 32'h0);
    spi_frame(24'h8F3300, 16, rx, oe_hi);
    check_eq("wr_oor_regs", regs_o, 32'h0000A500);
    check_eq("wr_oor_strobes", strobe_cnt - s0, 0);

    // Abort after four data bits, then a complete frame.
    spi_frame(24'h825A00, 12, rx, oe_hi);
    check_eq("abort_regs", regs_o, 32'h0000A500);
    check_eq("abort_strobes", strobe_cnt - s0, 0);
    spi_frame(24'h825A00, 16, rx, oe_hi);
    check_eq("after_abort_regs", regs_o, 32'h005AA500);
    check_eq("after_abort_strobes", strobe_cnt - s0, 1);
    check_eq("after_abort_saddr", {28'h0, strobe_addr}, 32'h2);

    // Burst write starting at reg3.
    s0 = strobe_cnt;
    spi_frame(24'h831122, 24, rx, oe_hi);
`ifdef SPI_AUTOINC_EN
    exp_regs = 32'h115AA522;
    check_eq("burst_strobes", strobe_cnt - s0, 2);
    check_eq("burst_saddr", {28'h0, strobe_addr}, 32'h0);
`else
    exp_regs = 32'h115AA500;
    check_eq("burst_strobes", strobe_cnt - s0, 1);
    check_eq("burst_saddr", {28'h0, strobe_addr}, 32'h3);
`endif
    check_eq("burst_regs", regs_o, exp_regs);

    // Burst read starting at reg3.
    spi_frame(24'h030000, 24, rx, oe_hi);
    check_eq("burst_rd_b1", {24'h0, rx[15:8]}, 32'h11);
`ifdef SPI_AUTOINC_EN
    check_eq("burst_rd_b2", {24'h0, rx[7:0]}, 32'h22);
`else
    check_eq("burst_rd_b2", {24'h0, rx[7:0]}, 32'h00);
`endif

    // ena dropped mid data byte behaves as an abort.
    s0 = strobe_cnt;
    fork
      spi_frame(24'h81FF00, 16, rx, oe_hi);
      begin
        wait_clk(130);
        ena = 1'b0;
        #1;
        check_eq("ena_low_oe", {31'h0, miso_oe}, 32'h0);
        wait_clk(30);
        ena = 1'b1;
      end
    join
    check_eq("ena_abort_regs", regs_o, exp_regs);
    check_eq("ena_abort_strobes", strobe_cnt - s0, 0);

    // Asynchronous reset in the middle of a frame.
    fork
      spi_frame(24'h825A00, 16, rx, oe_hi);
      begin
        wait_clk(40);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_regs", regs_o, 32'h0);
        check_eq("async_rst_oe", {31'h0, miso_oe}, 32'h0);
        check_eq("async_rst_miso", {31'h0, miso_o}, 32'h0);
        check_eq("async_rst_strobe", {31'h0, wr_strobe_o}, 32'h0);
        check_eq("async_rst_waddr", {28'h0, wr_addr_o}, 32'h0);
      end
    join
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(4);
    s0 = strobe_cnt;
    spi_frame(24'h807700, 16, rx, oe_hi);
    check_eq("post_rst_regs", regs_o, 32'h00000077);
    check_eq("post_rst_strobes", strobe_cnt - s0, 1);
    check_eq("post_rst_saddr", {28'h0, strobe_addr}, 32'h0);
    spi_frame(24'h000000, 16, rx, oe_hi);
    check_eq("post_rst_rd", {24'h0, rx[7:0]}, 32'h77);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_reg_target.md
Name: spi_reg_target

Overview:
- SPI mode-0 target (responder) inside hackathon_top. The external host or cocotb bench drives it as initiator through dedicated input pins.
- Decodes 2-byte command frames into a small 8-bit register file, which the rest of the design consumes.
- Returns register contents on a MISO pin routed to uo_out.
- SCLK/CS_N/MOSI are asynchronous to clk and are synchronized internally.

Parameters:
- NUM_REGS, 4: number of 8-bit read/write registers (2..16).
- SYNC_STAGES, 2: synchronizer flops per SPI input (>=2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  design selected; when 0, block behaves as if cs_n_i=1.
- sclk_i  input  1  SPI clock from host, idle low.
- cs_n_i  input  1  chip select, active low.
- mosi_i  input  1  host-to-target data.
- miso_o  output  1  target-to-host data.
- miso_oe  output  1  high while the synchronized CS is active (drives uio_oe bit).
- regs_o  output  NUM_REGS*8  flat register file; reg k occupies bits [8k+7:8k].
- wr_strobe_o  output  1  one-clk pulse when a register is written.
- wr_addr_o  output  4  address of the last write; holds its value between writes.

Behaviour:
- Reset: async assert, sync deassert. All regs 0x00, miso_o=0, miso_oe=0, wr_strobe_o=0, wr_addr_o=0, FSM=IDLE.
- Sampling:
  - All three SPI inputs pass through SYNC_STAGES flops, then a 1-flop edge detector.
  - Events are acted on SYNC_STAGES+1 clk cycles after the input changes.
  - Host SCLK must be <= clk/4.
- Mode 0:
  - MOSI sampled on SCLK rising edges.
  - miso_o updated on SCLK falling edges.
  - Both are MSB first.
- Frame format:
  - Byte 0 = {rw, addr[6:0]}; rw=1 means write.
  - Byte 1 = data (write) or returned data (read).
- FSM states: IDLE, CMD, DATA, DRAIN.
  - IDLE -> CMD on CS falling; bit counter cleared.
  - CMD: shift 8 bits. On the 8th rising edge, latch rw/addr. If read, load the shift-out register with reg[addr]. Then -> DATA.
  - DATA: shift 8 bits.
    - On the 8th rising edge of a write, reg[addr] is updated and wr_strobe_o pulses in the same clk cycle; wr_addr_o=addr.
    - Then -> DRAIN (or next DATA byte, see Optional Feature).
  - DRAIN: ignore further SCLK; miso_o=0.
  - Any state -> IDLE on CS rising (or ena low).
- MISO timing:
  - In CMD, miso_o=0.
  - The MSB of the read data appears on the falling edge following the 8th CMD rising edge. Each later falling edge shifts out the next bit.
- Out-of-range address (addr >= NUM_REGS): read returns 0x00; write is ignored with no strobe.
- CS deasserted mid-frame: frame aborted, no write occurs, partial bits discarded, and the next CS low starts a fresh CMD.
- CS rising and an SCLK edge in the same synchronized cycle: CS wins.
- ena low mid-frame: identical to a CS abort.
- miso_oe = ~synchronized cs_n & ena.

Optional Feature:
- Macro: SPI_AUTOINC_EN.
- Defined:
  - After each data byte the FSM stays in DATA and addr increments by 1, wrapping from NUM_REGS-1 to 0.
  - Burst writes strobe once per byte.
  - Burst reads preload the next register on each byte's 8th rising edge.
- Undefined: single data byte per frame; DRAIN as above.

Decomposition:
- Shared package spi_target_pkg:
  - state enum (IDLE, CMD, DATA, DRAIN).
  - CMD_RW_BIT=7.
  - ADDR_W=4.
  - BYTE_W=8.
- One sub-module: spi_sync_edge, a parameterized SYNC_STAGES synchronizer plus rise/fall pulse detector. It is instantiated for sclk and cs_n; mosi uses only the synchronizer.
- The register file and FSM stay in spi_reg_target.

Test Plan:
- Reset, then write frame 0x81,0xA5 -> regs_o[15:8]=0xA5, wr_strobe_o one pulse with wr_addr_o=1, other regs 0x00.
- After that write, read frame 0x01,0x00 -> MISO bits sampled on host rising edges of byte 1 = 0xA5; miso_oe high only while CS low.
- Read address 0x7F, and write 0x8F,0x33 -> read returns 0x00; no strobe; regs_o unchanged.
- Write 0x82,0x5A with CS raised after 4 data bits -> reg2 stays 0x00, no strobe. A following full frame 0x82,0x5A then succeeds.
- Assert rst_n low mid-frame with regs non-zero -> immediate (async) return of all outputs to reset values; the next frame decodes correctly.
- With SPI_AUTOINC_EN, burst write 0x83,0x11,0x22 -> reg3=0x11, reg0=0x22 (wrap), two strobes. Without the macro, reg3=0x11, reg0 unchanged, one strobe.
